// File: rtl/serv_seq_pkg.sv
// Shared types and helpers for the buffer-register sequencer.
package serv_seq_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SHAMT_W = 5;

   // Sequencer phases
   typedef enum logic [2:0] {
      SEQ_IDLE     = 3'd0,
      SEQ_INIT     = 3'd1,
      SEQ_MEM_WAIT = 3'd2,
      SEQ_SHIFT    = 3'd3,
      SEQ_RUN      = 3'd4,
      SEQ_DONE     = 3'd5
   } seq_state_e;

   // Memory access size encodings
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Number of datapath cycles needed to cover one 32-bit pass
   function automatic int unsigned chunks_f(input int unsigned bits_per_cycle);
      return DATA_W / bits_per_cycle;
   endfunction

   // Half accesses need an even address, word accesses a 4-byte aligned one
   function automatic logic misaligned_f(input logic [1:0] size, input logic [1:0] lsb);
      return ((size == SZ_HALF) && lsb[0]) || ((size == SZ_WORD) && (lsb != 2'b00));
   endfunction

endpackage

// File: rtl/serv_seq_cnt.sv
// Chunk counter: synchronous clear, wrap on terminal value, terminal-count flag.
module serv_seq_cnt #(
   parameter int unsigned W = 5
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_inc,
   input  logic [W-1:0] i_last,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);

   // Terminal count is combinational so the sequencer can leave on the last chunk
   assign o_tc = (o_cnt == i_last);

   // Count up while enabled, wrapping back to zero after the terminal value
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         o_cnt <= '0;
      end else if (i_inc) begin
         o_cnt <= o_tc ? '0 : o_cnt + W'(1);
      end
   end

endmodule

// File: rtl/serv_bufreg_seq.sv
// Buffer-register sequencer: init -> (bus wait) -> (coarse shift) -> run -> done.
// Optional misaligned-access trap enabled by defining SERV_BUFREG_SEQ_MISALIGN_EN.
module serv_bufreg_seq
   import serv_seq_pkg::*;
#(
   parameter int unsigned BITS_PER_CYCLE = 1,
   parameter int unsigned LB             = $clog2(BITS_PER_CYCLE)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_op_valid,
   output logic          o_op_ready,
   input  logic          i_op_init,
   input  logic          i_op_mem,
   input  logic          i_op_shift,
   input  logic [1:0]    i_mem_size,
   input  logic [4:0]    i_shamt,
   input  logic [1:0]    i_lsb,
   output logic          o_dbus_cyc,
   input  logic          i_dbus_ack,
   output logic          o_cnt0,
   output logic          o_cnt1,
   output logic          o_en,
   output logic          o_init,
   output logic          o_shift_op,
   output logic [LB:0]   o_shift_counter_lsb,
   output logic          o_done,
   output logic          o_misalign
);

   localparam int unsigned CHUNKS = chunks_f(BITS_PER_CYCLE);
   localparam int unsigned CW     = SHAMT_W - LB;

   localparam logic [2:0] ST_IDLE     = SEQ_IDLE;
   localparam logic [2:0] ST_INIT     = SEQ_INIT;
   localparam logic [2:0] ST_MEM_WAIT = SEQ_MEM_WAIT;
   localparam logic [2:0] ST_SHIFT    = SEQ_SHIFT;
   localparam logic [2:0] ST_RUN      = SEQ_RUN;
   localparam logic [2:0] ST_DONE     = SEQ_DONE;

   logic [2:0]         state_q;
   logic [2:0]         state_d;
   logic               accept;

   logic               init_q;
   logic               mem_q;
   logic               shift_q;
   logic [1:0]         size_q;
   logic [SHAMT_W-1:0] shamt_q;

   logic [CW-1:0]      shamt_hi_q;
   logic [CW-1:0]      shamt_hi_in;
   logic [LB:0]        shamt_lo_ext;

   logic [CW-1:0]      cnt;
   logic [CW-1:0]      cnt_last;
   logic               cnt_tc;
   logic               cnt_inc;
   logic               cnt_clr;

   logic               misalign_hit;
   logic               misalign_q;
   logic               unused_bits;

   assign accept      = i_op_valid && (state_q == ST_IDLE);
   assign shamt_hi_q  = shamt_q[SHAMT_W-1:LB];
   assign shamt_hi_in = i_shamt[SHAMT_W-1:LB];

   // In-chunk shift amount; nothing left below the chunk boundary when one bit per cycle
   generate
      if (LB == 0) begin : g_lo_none
         assign shamt_lo_ext = '0;
      end else begin : g_lo_bits
         assign shamt_lo_ext = {1'b0, shamt_q[LB-1:0]};
      end
   endgenerate

`ifdef SERV_BUFREG_SEQ_MISALIGN_EN
   assign misalign_hit = mem_q && misaligned_f(size_q, i_lsb);
   assign unused_bits  = init_q;

   // Remember that the access trapped so DONE can flag it
   always_ff @(posedge i_clk) begin
      if (i_rst || accept) begin
         misalign_q <= 1'b0;
      end else if ((state_q == ST_INIT) && cnt_tc && misalign_hit) begin
         misalign_q <= 1'b1;
      end
   end
`else
   assign misalign_hit = 1'b0;
   assign misalign_q   = 1'b0;
   assign unused_bits  = ^{init_q, size_q, i_lsb};
`endif

   // Chunk counter shared by INIT, SHIFT and RUN; cleared on every phase change
   assign cnt_last = (state_q == ST_SHIFT) ? (shamt_hi_q - CW'(1)) : CW'(CHUNKS - 1);
   assign cnt_inc  = (state_q == ST_INIT) || (state_q == ST_SHIFT) || (state_q == ST_RUN);
   assign cnt_clr  = (state_d != state_q);

   serv_seq_cnt #(
      .W (CW)
   ) u_cnt (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (cnt_clr),
      .i_inc  (cnt_inc),
      .i_last (cnt_last),
      .o_cnt  (cnt),
      .o_tc   (cnt_tc)
   );

   // Capture the op fields at accept; they stay frozen for the whole operation
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         init_q  <= 1'b0;
         mem_q   <= 1'b0;
         shift_q <= 1'b0;
         size_q  <= 2'b00;
         shamt_q <= '0;
      end else if (accept) begin
         init_q  <= i_op_init;
         mem_q   <= i_op_mem;
         shift_q <= i_op_shift;
         size_q  <= i_mem_size;
         shamt_q <= i_shamt;
      end
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (i_op_init) begin
                  state_d = ST_INIT;
               end else if (i_op_shift && (shamt_hi_in != '0)) begin
                  state_d = ST_SHIFT;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_INIT: begin
            if (cnt_tc) begin
               if (mem_q) begin
                  state_d = misalign_hit ? ST_DONE : ST_MEM_WAIT;
               end else if (shift_q && (shamt_hi_q != '0)) begin
                  state_d = ST_SHIFT;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_MEM_WAIT: begin
            if (i_dbus_ack) begin
               state_d = ST_RUN;
            end
         end
         ST_SHIFT: begin
            if (cnt_tc) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cnt_tc) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode from the registered state
   always_comb begin
      o_op_ready          = 1'b0;
      o_dbus_cyc          = 1'b0;
      o_cnt0              = 1'b0;
      o_cnt1              = 1'b0;
      o_en                = 1'b0;
      o_init              = 1'b0;
      o_shift_op          = 1'b0;
      o_shift_counter_lsb = '0;
      o_done              = 1'b0;
      o_misalign          = 1'b0;
      case (state_q)
         ST_IDLE: begin
            o_op_ready = 1'b1;
         end
         ST_INIT: begin
            o_en   = 1'b1;
            o_init = 1'b1;
            o_cnt0 = (cnt == '0);
            o_cnt1 = (cnt == CW'(1));
         end
         ST_MEM_WAIT: begin
            o_dbus_cyc = 1'b1;
         end
         ST_SHIFT: begin
            o_en = 1'b1;
         end
         ST_RUN: begin
            o_en                = 1'b1;
            o_cnt0              = (cnt == '0);
            o_cnt1              = (cnt == CW'(1));
            o_shift_op          = shift_q;
            o_shift_counter_lsb = shamt_lo_ext;
         end
         ST_DONE: begin
            o_done     = 1'b1;
            o_misalign = misalign_q;
         end
         default: begin
            o_op_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_serv_bufreg_seq.sv
// Directed bench for serv_bufreg_seq at 1, 4 and 8 bits per cycle.
module tb_serv_bufreg_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [2:0] op_valid, op_init, op_mem, op_shift, ack;
   logic [1:0] mem_size [3];
   logic [4:0] shamt    [3];
   logic [1:0] lsb      [3];

   logic [2:0] op_ready, dbus_cyc, cnt0, cnt1, en, init_o, shift_op, done, misalign;
   logic [0:0] scl0;
   logic [2:0] scl1;
   logic [3:0] scl2;

   serv_bufreg_seq #(.BITS_PER_CYCLE(1)) u_w1 (
      .i_clk(clk), .i_rst(rst), .i_op_valid(op_valid[0]), .o_op_ready(op_ready[0]),
      .i_op_init(op_init[0]), .i_op_mem(op_mem[0]), .i_op_shift(op_shift[0]),
      .i_mem_size(mem_size[0]), .i_shamt(shamt[0]), .i_lsb(lsb[0]),
      .o_dbus_cyc(dbus_cyc[0]), .i_dbus_ack(ack[0]), .o_cnt0(cnt0[0]), .o_cnt1(cnt1[0]),
      .o_en(en[0]), .o_init(init_o[0]), .o_shift_op(shift_op[0]),
      .o_shift_counter_lsb(scl0), .o_done(done[0]), .o_misalign(misalign[0]));

   serv_bufreg_seq #(.BITS_PER_CYCLE(4)) u_w4 (
      .i_clk(clk), .i_rst(rst), .i_op_valid(op_valid[1]), .o_op_ready(op_ready[1]),
      .i_op_init(op_init[1]), .i_op_mem(op_mem[1]), .i_op_shift(op_shift[1]),
      .i_mem_size(mem_size[1]), .i_shamt(shamt[1]), .i_lsb(lsb[1]),
      .o_dbus_cyc(dbus_cyc[1]), .i_dbus_ack(ack[1]), .o_cnt0(cnt0[1]), .o_cnt1(cnt1[1]),
      .o_en(en[1]), .o_init(init_o[1]), .o_shift_op(shift_op[1]),
      .o_shift_counter_lsb(scl1), .o_done(done[1]), .o_misalign(misalign[1]));

   serv_bufreg_seq #(.BITS_PER_CYCLE(8)) u_w8 (
      .i_clk(clk), .i_rst(rst), .i_op_valid(op_valid[2]), .o_op_ready(op_ready[2]),
      .i_op_init(op_init[2]), .i_op_mem(op_mem[2]), .i_op_shift(op_shift[2]),
      .i_mem_size(mem_size[2]), .i_shamt(shamt[2]), .i_lsb(lsb[2]),
      .o_dbus_cyc(dbus_cyc[2]), .i_dbus_ack(ack[2]), .o_cnt0(cnt0[2]), .o_cnt1(cnt1[2]),
      .o_en(en[2]), .o_init(init_o[2]), .o_shift_op(shift_op[2]),
      .o_shift_counter_lsb(scl2), .o_done(done[2]), .o_misalign(misalign[2]));

   int n_total = 0;
   int n_bad   = 0;

   // Per-operation measurements, cycle 1 = first cycle after accept
   int         m_acc, m_done, m_init, m_en, m_dbus, m_en_dbus, m_shop;
   int         m_cnt0, m_cnt1, m_c0a, m_c0b, m_ready;
   logic [3:0] m_scl;
   logic       m_mis;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] get_scl(input int k);
      case (k)
         0:       return {3'b000, scl0};
         1:       return {1'b0, scl1};
         default: return scl2;
      endcase
   endfunction

   // Issue one op on instance k and record what the sequencer does until o_done
   task automatic run_op(input int k, input logic init, input logic mem, input logic shift,
                         input logic [1:0] size, input logic [4:0] sh, input logic [1:0] lb,
                         input int ack_dly, input bit keep);
      int dbc;
      dbc = 0;
      @(negedge clk);
      op_valid[k] = 1'b1; op_init[k] = init; op_mem[k] = mem; op_shift[k] = shift;
      mem_size[k] = size; shamt[k] = sh; lsb[k] = lb;
      m_acc = int'(op_ready[k]);
      m_done = 0; m_init = 0; m_en = 0; m_dbus = 0; m_en_dbus = 0; m_shop = 0;
      m_cnt0 = 0; m_cnt1 = 0; m_c0a = 0; m_c0b = 0; m_ready = 0; m_scl = '0; m_mis = 1'b0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(negedge clk);
         if (!keep) op_valid[k] = 1'b0;
         else       shamt[k] = 5'($urandom_range(0, 31));
         ack[k] = 1'b0;
         if (op_ready[k]) m_ready++;
         if (init_o[k])   m_init++;
         if (en[k])       begin m_en++; m_scl = get_scl(k); end
         if (shift_op[k]) m_shop++;
         if (cnt1[k])     m_cnt1++;
         if (cnt0[k]) begin
            m_cnt0++;
            if (m_cnt0 == 1) m_c0a = cyc;
            if (m_cnt0 == 2) m_c0b = cyc;
         end
         if (dbus_cyc[k]) begin
            m_dbus++;
            dbc++;
            if (en[k]) m_en_dbus++;
            if (dbc == ack_dly) ack[k] = 1'b1;
         end
         if (done[k]) begin
            m_done = cyc;
            m_mis  = misalign[k];
            break;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      op_valid = '0; op_init = '0; op_mem = '0; op_shift = '0; ack = '0;
      for (int i = 0; i < 3; i++) begin
         mem_size[i] = 2'b00; shamt[i] = '0; lsb[i] = 2'b00;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", op_ready, 3'b111);
      check("rst_en", en, 3'b000);
      check("rst_done", done, 3'b000);
      check("rst_dbus", dbus_cyc, 3'b000);
      check("rst_scl", {scl0, scl1, scl2}, 0);

      // W=1 init pass, no mem, no shift
      run_op(0, 1'b1, 1'b0, 1'b0, 2'b10, 5'd0, 2'b00, 0, 1'b0);
      check("w1_acc", m_acc, 1);
      check("w1_done", m_done, 65);
      check("w1_init", m_init, 32);
      check("w1_en", m_en, 64);
      check("w1_cnt0_n", m_cnt0, 2);
      check("w1_cnt0_a", m_c0a, 1);
      check("w1_cnt0_b", m_c0b, 33);
      check("w1_cnt1_n", m_cnt1, 2);
      check("w1_dbus", m_dbus, 0);
      @(negedge clk);
      check("w1_done_1cyc", done[0], 0);
      check("w1_idle", op_ready[0], 1);

      // W=4 shift by 13: 3 coarse chunks then fine shift of 1
      run_op(1, 1'b0, 1'b0, 1'b1, 2'b00, 5'd13, 2'b00, 0, 1'b0);
      check("w4sh_done", m_done, 12);
      check("w4sh_en", m_en, 11);
      check("w4sh_shop", m_shop, 8);
      check("w4sh_scl", m_scl, 1);
      check("w4sh_init", m_init, 0);
      check("w4sh_cnt0", m_cnt0, 1);

      // W=4 plain run: 9 cycles
      run_op(1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd7, 2'b00, 0, 1'b0);
      check("w4run_done", m_done, 9);
      check("w4run_shop", m_shop, 0);
      check("w4run_scl", m_scl, 3);

      // W=8 load with init and ack after 5 wait cycles
      run_op(2, 1'b1, 1'b1, 1'b0, 2'b10, 5'd0, 2'b00, 5, 1'b0);
      check("w8mem_done", m_done, 14);
      check("w8mem_dbus", m_dbus, 5);
      check("w8mem_en_dbus", m_en_dbus, 0);
      check("w8mem_en", m_en, 8);
      check("w8mem_init", m_init, 4);

      // Reset in the middle of RUN
      @(negedge clk);
      op_valid[0] = 1'b1; op_init[0] = 1'b0; op_mem[0] = 1'b0; op_shift[0] = 1'b0;
      @(negedge clk);
      op_valid[0] = 1'b0;
      repeat (8) @(negedge clk);
      check("midrun_en", en[0], 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrun_rst_ready", op_ready[0], 1);
      check("midrun_rst_en", en[0], 0);
      check("midrun_rst_done", done[0], 0);
      check("midrun_rst_dbus", dbus_cyc[0], 0);
      run_op(0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 0, 1'b0);
      check("midrun_after", m_done, 33);

      // Reset in the middle of MEM_WAIT
      @(negedge clk);
      op_valid[2] = 1'b1; op_init[2] = 1'b1; op_mem[2] = 1'b1; op_shift[2] = 1'b0;
      @(negedge clk);
      op_valid[2] = 1'b0;
      repeat (5) @(negedge clk);
      check("midmem_dbus", dbus_cyc[2], 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midmem_rst_dbus", dbus_cyc[2], 0);
      check("midmem_rst_ready", op_ready[2], 1);
      check("midmem_rst_en", en[2], 0);
      run_op(2, 1'b1, 1'b1, 1'b0, 2'b10, 5'd0, 2'b00, 5, 1'b0);
      check("midmem_after", m_done, 14);

      // Word store with misaligned and aligned address
      run_op(1, 1'b1, 1'b1, 1'b0, 2'b10, 5'd0, 2'b10, 2, 1'b0);
`ifdef SERV_BUFREG_SEQ_MISALIGN_EN
      check("mis_done", m_done, 9);
      check("mis_flag", m_mis, 1);
      check("mis_dbus", m_dbus, 0);
`else
      check("mis_done", m_done, 19);
      check("mis_flag", m_mis, 0);
      check("mis_dbus", m_dbus, 2);
`endif
      run_op(1, 1'b1, 1'b1, 1'b0, 2'b10, 5'd0, 2'b00, 2, 1'b0);
      check("align_done", m_done, 19);
      check("align_flag", m_mis, 0);
      check("align_dbus", m_dbus, 2);

      // Valid held high with shamt changing every cycle
      run_op(1, 1'b0, 1'b0, 1'b1, 2'b00, 5'd13, 2'b00, 0, 1'b1);
      check("hold1_done", m_done, 12);
      check("hold1_scl", m_scl, 1);
      check("hold1_ready", m_ready, 0);
      run_op(1, 1'b0, 1'b0, 1'b1, 2'b00, 5'd6, 2'b00, 0, 1'b1);
      check("hold2_acc", m_acc, 1);
      check("hold2_done", m_done, 10);
      check("hold2_scl", m_scl, 2);
      check("hold2_ready", m_ready, 0);
      @(negedge clk);
      op_valid[1] = 1'b0;
      @(negedge clk);
      check("hold_idle", op_ready[1], 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/serv_bufreg_seq.md
Name: serv_bufreg_seq

Overview:
- Sequencer that drives the bit/chunk-serial buffer register datapath through one operation.
- Phases: init (accumulate rs1+imm), optional bus wait, optional coarse shift, run (stream out).
- Generates the count strobes, enable, init and shift-counter controls, plus a one-cycle completion pulse.
- Sits between instruction decode (op handshake) and the buffer register / data bus interface.

Parameters:
- BITS_PER_CYCLE, 1, datapath width per cycle; legal values 1, 4, 8.
- LB, $clog2(BITS_PER_CYCLE), width of the in-chunk shift field.
- CHUNKS, 32/BITS_PER_CYCLE, derived; cycles per 32-bit pass.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_op_valid  in  1  operation request
- o_op_ready  out  1  high only in IDLE; op accepted on valid&ready
- i_op_init  in  1  op needs init phase (address/operand accumulate)
- i_op_mem  in  1  op is load/store; bus wait after init
- i_op_shift  in  1  op is a shift
- i_mem_size  in  2  00 byte, 01 half, 10 word
- i_shamt  in  5  shift amount, sampled at accept
- i_lsb  in  2  address LSBs from buffer register
- o_dbus_cyc  out  1  bus request, high in MEM_WAIT
- i_dbus_ack  in  1  bus acknowledge
- o_cnt0  out  1  first chunk of a pass
- o_cnt1  out  1  second chunk of a pass
- o_en  out  1  buffer register enable
- o_init  out  1  buffer register init select
- o_shift_op  out  1  shift active in RUN
- o_shift_counter_lsb  out  LB+1  in-chunk shift amount; MSB always 0
- o_done  out  1  one-cycle completion pulse
- o_misalign  out  1  misaligned access, pulses with o_done (feature only)

Behaviour:
- Registers:
  - state: IDLE, INIT, MEM_WAIT, SHIFT, RUN, DONE
  - cnt: 5-LB bits
  - latched op fields: init, mem, shift, size, shamt
- All outputs decode combinationally from registered state.
- Reset (any state, mid-operation included): state IDLE, cnt 0, latches 0. The next cycle shows o_op_ready=1 and every other output 0. Any bus request in flight is dropped.
- IDLE, on accept:
  - i_op_init=1: go to INIT.
  - else i_op_shift=1 and shamt[4:LB]!=0: go to SHIFT.
  - else go to RUN.
  - cnt cleared on every transition.
- INIT: o_en=o_init=1 for CHUNKS cycles.
  - o_cnt0 when cnt==0; o_cnt1 when cnt==1.
  - At cnt==CHUNKS-1 go to MEM_WAIT if mem, else SHIFT or RUN by the rules above.
- MEM_WAIT: o_dbus_cyc=1, o_en=0. Stays until i_dbus_ack, then RUN. An ack in any other state is ignored.
- SHIFT: o_en=1, o_init=0 for shamt[4:LB] cycles, cnt counting up; then RUN. Performs the coarse whole-chunk shift.
- RUN: o_en=1 for CHUNKS cycles.
  - o_cnt0/o_cnt1 as in INIT.
  - o_shift_op=latched shift.
  - o_shift_counter_lsb={1'b0, shamt[LB-1:0]}; all zeros when LB=0.
  - Last chunk goes to DONE.
- DONE: o_done=1 for one cycle, then IDLE. New ops are accepted one cycle after DONE, never back to back within DONE.
- Count wrap: cnt wraps at CHUNKS-1 → 0, so no overflow for CHUNKS=32 with 5 bits.
- i_op_valid outside IDLE is ignored, and i_shamt is not resampled.
- Latency, no mem, no shift: accept to o_done = CHUNKS*(init?2:1)+1 cycles.
  - W=1: 65 cycles.
  - W=4 no init: 9 cycles.

Optional Feature:
- Macro: SERV_BUFREG_SEQ_MISALIGN_EN.
- Defined:
  - On the INIT→MEM_WAIT edge, i_lsb is checked against the latched size: half with lsb[0]=1, or word with lsb!=00.
  - A hit goes to DONE instead of MEM_WAIT, with o_misalign=1 during DONE; o_dbus_cyc is never raised.
- Undefined: o_misalign tied 0; no check.

Decomposition:
- Shared package serv_seq_pkg holds:
  - state enum typedef
  - mem size encodings (SZ_BYTE/SZ_HALF/SZ_WORD)
  - CHUNKS derivation function
- One sub-module is natural: serv_seq_cnt, a chunk counter with clear, wrap and terminal-count flag.

Test Plan:
- W=1, init=1, mem=0, shift=0 → o_init high 32 cycles, o_en 64 cycles, o_cnt0 at cycles 1 and 33, o_done at cycle 65.
- W=4, shift=1, shamt=13 → SHIFT 3 cycles, RUN 8 cycles with o_shift_counter_lsb=001, o_done at cycle 12.
- W=8, mem=1, init=1, ack delayed 5 cycles → o_dbus_cyc high exactly 5 cycles, o_en low during them, then 4 RUN cycles and o_done.
- i_rst asserted mid-RUN and mid-MEM_WAIT → next cycle IDLE, o_op_ready=1, o_en=o_dbus_cyc=o_done=0; a new op then completes normally.
- Feature on, W=4, word store, i_lsb=10 → o_done and o_misalign together one cycle after INIT ends, o_dbus_cyc never high. Same with i_lsb=00 → normal MEM_WAIT.
- i_op_valid held high continuously with varying i_shamt → exactly one accept per IDLE, shamt frozen at the accept value.
